sram_controller: RTL and testbench
==================================

# sram_controller

Multi-cycle controller that sits between the MEM stage of the pipeline and an external 16-bit asynchronous SRAM, replacing the single-cycle 64-word data memory. It accepts one 32-bit load or store from the pipeline and splits it into two sequenced 16-bit SRAM accesses. It holds `ready` low to freeze the pipeline until the access completes. Address mapping keeps the data-segment convention: byte address 1024 is word 0.

## Interface
- `ACCESS_CYCLES`, default 2: cycles each 16-bit SRAM access phase lasts; legal values are 1 to 15.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset; synchronous and active-low.
- `MEMread`  in  1  load request; held stable by the pipeline while `ready`=0.
- `MEMwrite`  in  1  store request; held stable while `ready`=0.
- `address`  in  32  byte address (data segment base 1024).
- `data`  in  32  store data.
- `MEM_result`  out  32  load result, registered.
- `ready`  out  1  1 means the pipeline may advance; 0 means freeze.
- `SRAM_DQ`  inout  16  SRAM data bus.
- `SRAM_ADDR`  out  18  SRAM half-word address.
- `SRAM_WE_N`  out  1  SRAM write enable, active-low.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_CE_N`, `SRAM_OE_N`  out  1 each  constant 0.

## Operation
- Word index computation:
  - `true_addr = address - 1024`, computed mod 2^32.
  - `widx = true_addr[18:2]`, 17 bits; higher bits are dropped, so addresses wrap.
  - Low half is at `{widx,1'b0}`; high half is at `{widx,1'b1}`.
- Request priority: `req = MEMread | MEMwrite`. If both are asserted, the access is a write.
- FSM states: IDLE, LOW, HIGH, DONE, plus a phase counter `cnt`.
  - IDLE: if `req`, go to LOW with `cnt`=0 and latch op type, `widx` and `data`. Otherwise stay in IDLE.
  - LOW: `SRAM_ADDR={widx,0}`. When `cnt==ACCESS_CYCLES-1`, go to HIGH with `cnt`=0. Otherwise increment `cnt`.
  - HIGH: `SRAM_ADDR={widx,1}`. Same counting rule as LOW; when done, go to DONE.
  - DONE: go to IDLE unconditionally. A request seen in IDLE on the following cycle is treated as a new access.
- Write phases:
  - `SRAM_WE_N`=0 for every cycle of LOW and HIGH.
  - `SRAM_DQ` carries `data[15:0]` during LOW and `data[31:16]` during HIGH.
- Read phases:
  - `SRAM_WE_N`=1 and `SRAM_DQ`=Z.
  - `SRAM_DQ` is captured into `MEM_result[15:0]` at the clock edge ending the last LOW cycle.
  - `SRAM_DQ` is captured into `MEM_result[31:16]` at the edge ending the last HIGH cycle.
- Write accesses leave `MEM_result` unchanged.
- Outside LOW and HIGH: `SRAM_DQ`=Z, `SRAM_WE_N`=1, `SRAM_ADDR`=0.
- `ready` is combinational: `(state==IDLE && !req) || state==DONE`.

## Timing
- Reset values: state=IDLE, `cnt`=0, `MEM_result`=0, `SRAM_WE_N`=1, `SRAM_ADDR`=0, `SRAM_DQ`=Z. `ready`=1 provided `req`=0.
- Latency: a request first seen in IDLE at cycle 0 gives `ready`=0 for cycles 0 to 2·N, where N=`ACCESS_CYCLES`. `ready`=1 in cycle 2·N+1 (DONE), and `MEM_result` is valid in that same cycle.
- `ready` drops in the same cycle the request appears; no cycle of the request is lost.
- Back-to-back requests: DONE is followed by IDLE. A new request costs 2·N+2 cycles per access in steady state.
- Request inputs change while `ready`=0: the latched values are used and input changes are ignored.
- Reset mid-access: at the next edge the FSM goes to IDLE and the bus is released. A partial write may remain in SRAM. The access is not retried.
- `rst` overrides any request on the same edge.

## Structure
- Shared package `sram_pkg` holds:
  - the state enum `sram_state_t` (IDLE, LOW, HIGH, DONE);
  - `DATA_BASE = 32'd1024`;
  - `SRAM_AW = 18` and `SRAM_DW = 16`.
- No sub-module: the FSM, counter and tri-state driver stay in one module.
- The bench provides a behavioral 2^18×16 SRAM model that is combinational-read and write-on-`WE_N`-low.

## Test plan
- Idle after reset, with `req`=0 → `ready`=1, `SRAM_WE_N`=1, `SRAM_DQ`=Z, `MEM_result`=0.
- N=2: write 0xDEADBEEF to 1024 →
  - SRAM[0]=0xBEEF and SRAM[1]=0xDEAD;
  - `ready` is 0 for cycles 0 to 4 and 1 in cycle 5.
- Read 1024 after the above write → `MEM_result`=0xDEADBEEF in the DONE cycle. Write 0x12345678 to 1028 → SRAM[2]=0x5678 and SRAM[3]=0x1234.
- `MEMread` and `MEMwrite` both 1 at 1032 with data 0xCAFEF00D → treated as a write; SRAM[4]=0xF00D, SRAM[5]=0xCAFE; `MEM_result` unchanged.
- Reset pulsed during HIGH of a write to 1036 → IDLE at the next edge, `WE_N`=1, bus Z, `MEM_result`=0. SRAM[6] is written and SRAM[7] is not.
- N=1, two back-to-back reads of 1024 then 1028 → DONE occurs in cycles 3 and 7, with the correct data each time.

Source files
------------

// File: rtl/sram_controller_pkg.sv
// rtl/sram_controller_pkg.sv - shared types and constants for the SRAM controller
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } sram_state_t;

    localparam logic [31:0] DATA_BASE = 32'd1024;
    localparam int          SRAM_AW   = 18;
    localparam int          SRAM_DW   = 16;

    // Byte address in the data segment -> 17-bit word index. Anything above
    // bit 18 of the rebased address is dropped, so the index wraps.
    function automatic logic [16:0] word_index(input logic [31:0] addr);
        return 17'((addr - DATA_BASE) >> 2);
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// rtl/sram_controller_if.sv - pipeline MEM-stage request/response bus
//
// master: pipeline side (drives MEMread/MEMwrite/address/data)
// slave : controller side (drives MEM_result/ready)
interface sram_controller_if;
    logic        MEMread;
    logic        MEMwrite;
    logic [31:0] address;
    logic [31:0] data;
    logic [31:0] MEM_result;
    logic        ready;

    modport master (
        output MEMread, MEMwrite, address, data,
        input  MEM_result, ready
    );

    modport slave (
        input  MEMread, MEMwrite, address, data,
        output MEM_result, ready
    );
endinterface

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit MEM-stage access split into two 16-bit async SRAM phases
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous, active-low reset
//   bus        - pipeline request/response (slave side); ready=0 freezes the pipeline
//   SRAM_DQ    - bidirectional 16-bit SRAM data bus
//   SRAM_ADDR  - SRAM half-word address
//   SRAM_WE_N  - SRAM write enable, active-low
//   SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N - tied low
module sram_controller
    import sram_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    sram_controller_if.slave    bus,
    inout  wire  [SRAM_DW-1:0]  SRAM_DQ,
    output logic [SRAM_AW-1:0]  SRAM_ADDR,
    output logic                SRAM_WE_N,
    output logic                SRAM_UB_N,
    output logic                SRAM_LB_N,
    output logic                SRAM_CE_N,
    output logic                SRAM_OE_N
);

    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

    sram_state_t         state;
    logic [3:0]          cnt;
    logic                is_wr;
    logic [16:0]         widx_q;
    logic [31:0]         data_q;
    logic [31:0]         mem_result_q;
    logic [SRAM_AW-1:0]  addr_q;
    logic                we_n_q;
    logic                dq_oe_q;
    logic [SRAM_DW-1:0]  dq_out_q;
    logic                req;

    assign req = bus.MEMread | bus.MEMwrite;

    // Bus outputs are registered one step ahead of the state they belong to,
    // so they are valid for the whole first cycle of each phase.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            is_wr        <= 1'b0;
            widx_q       <= 17'd0;
            data_q       <= 32'd0;
            mem_result_q <= 32'd0;
            addr_q       <= '0;
            we_n_q       <= 1'b1;
            dq_oe_q      <= 1'b0;
            dq_out_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        // A simultaneous read+write request is a write.
                        state    <= LOW;
                        cnt      <= 4'd0;
                        is_wr    <= bus.MEMwrite;
                        widx_q   <= word_index(bus.address);
                        data_q   <= bus.data;
                        addr_q   <= {word_index(bus.address), 1'b0};
                        we_n_q   <= ~bus.MEMwrite;
                        dq_oe_q  <= bus.MEMwrite;
                        dq_out_q <= bus.data[15:0];
                    end
                end
                LOW: begin
                    if (cnt == LAST_CNT) begin
                        state    <= HIGH;
                        cnt      <= 4'd0;
                        addr_q   <= {widx_q, 1'b1};
                        dq_out_q <= data_q[31:16];
                        if (!is_wr) begin
                            mem_result_q[15:0] <= SRAM_DQ;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                HIGH: begin
                    if (cnt == LAST_CNT) begin
                        state    <= DONE;
                        cnt      <= 4'd0;
                        addr_q   <= '0;
                        we_n_q   <= 1'b1;
                        dq_oe_q  <= 1'b0;
                        if (!is_wr) begin
                            mem_result_q[31:16] <= SRAM_DQ;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // While reset is held the write strobe and data drivers are forced off,
    // so an aborted write stops touching the SRAM immediately instead of
    // running on until the reset edge.
    assign SRAM_DQ   = (dq_oe_q && rst) ? dq_out_q : {SRAM_DW{1'bz}};
    assign SRAM_WE_N = we_n_q | ~rst;
    assign SRAM_ADDR = addr_q;

    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    assign bus.MEM_result = mem_result_q;
    assign bus.ready      = (state == IDLE && !req) || (state == DONE);

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - directed self-checking bench for sram_controller (N=2 and N=1)
module tb_sram_controller;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sram_controller_if bus_a ();
    sram_controller_if bus_b ();

    wire  [15:0] dq_a;
    logic [17:0] addr_a;
    logic        we_a_n, ub_a, lb_a, ce_a, oe_a;
    wire  [15:0] dq_b;
    logic [17:0] addr_b;
    logic        we_b_n, ub_b, lb_b, ce_b, oe_b;

    sram_controller #(.ACCESS_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a),
        .SRAM_DQ(dq_a), .SRAM_ADDR(addr_a), .SRAM_WE_N(we_a_n),
        .SRAM_UB_N(ub_a), .SRAM_LB_N(lb_a), .SRAM_CE_N(ce_a), .SRAM_OE_N(oe_a)
    );

    sram_controller #(.ACCESS_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b),
        .SRAM_DQ(dq_b), .SRAM_ADDR(addr_b), .SRAM_WE_N(we_b_n),
        .SRAM_UB_N(ub_b), .SRAM_LB_N(lb_b), .SRAM_CE_N(ce_b), .SRAM_OE_N(oe_b)
    );

    // Behavioral SRAMs: combinational read while WE_N=1, write while WE_N=0.
    logic [15:0] mem_a [0:262143];
    logic [15:0] mem_b [0:262143];

    assign dq_a = we_a_n ? mem_a[addr_a] : 16'hzzzz;
    assign dq_b = we_b_n ? mem_b[addr_b] : 16'hzzzz;

    always @(posedge clk) if (!we_a_n) mem_a[addr_a] <= dq_a;
    always @(posedge clk) if (!we_b_n) mem_b[addr_b] <= dq_b;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            bus_a.MEMread = rd; bus_a.MEMwrite = wr; bus_a.address = a; bus_a.data = d;
        end else begin
            bus_b.MEMread = rd; bus_b.MEMwrite = wr; bus_b.address = a; bus_b.data = d;
        end
    endtask

    // Called at posedge+1. Returns the cycle (relative to the request) in
    // which ready first rises, or -1 if it never does within the budget.
    task automatic access(input int sel, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          output int done_c, output logic [31:0] res);
        logic rdy;
        drive(sel, rd, wr, a, d);
        done_c = -1;
        res    = 32'h0;
        for (int c = 0; c < 40 && done_c < 0; c++) begin
            if (c > 0) begin
                @(posedge clk); #2;
            end else begin
                #1;
            end
            rdy = (sel == 0) ? bus_a.ready : bus_b.ready;
            if (rdy) begin
                done_c = c;
                res    = (sel == 0) ? bus_a.MEM_result : bus_b.MEM_result;
                drive(sel, 1'b0, 1'b0, a, d);
            end
        end
        @(posedge clk); #1;
    endtask

    int          dc;
    int          first_c, second_c;
    logic [31:0] res, r1, r2;

    initial begin
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;

        // Reset / idle state
        check("rst_ready_a",  {31'h0, bus_a.ready}, 32'h1);
        check("rst_we_n_a",   {31'h0, we_a_n}, 32'h1);
        check("rst_result_a", bus_a.MEM_result, 32'h0);
        check("rst_addr_a",   {14'h0, addr_a}, 32'h0);
        check("rst_ub_n_a",   {28'h0, ub_a, lb_a, ce_a, oe_a}, 32'h0);
        check("rst_ready_b",  {31'h0, bus_b.ready}, 32'h1);
        @(posedge clk); #1;

        // N=2: write, read back, second write
        access(0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, dc, res);
        check("wr1024_lat", dc, 32'd5);
        check("wr1024_lo",  {16'h0, mem_a[0]}, 32'h0000BEEF);
        check("wr1024_hi",  {16'h0, mem_a[1]}, 32'h0000DEAD);

        access(0, 1'b1, 1'b0, 32'd1024, 32'h0, dc, res);
        check("rd1024_lat",  dc, 32'd5);
        check("rd1024_data", res, 32'hDEADBEEF);

        access(0, 1'b0, 1'b1, 32'd1028, 32'h12345678, dc, res);
        check("wr1028_lo", {16'h0, mem_a[2]}, 32'h00005678);
        check("wr1028_hi", {16'h0, mem_a[3]}, 32'h00001234);

        // Read and write together -> write; result register untouched
        access(0, 1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, dc, res);
        check("both_lat",    dc, 32'd5);
        check("both_lo",     {16'h0, mem_a[4]}, 32'h0000F00D);
        check("both_hi",     {16'h0, mem_a[5]}, 32'h0000CAFE);
        check("both_result", bus_a.MEM_result, 32'hDEADBEEF);

        // Known contents at 1036, then abort a write there during HIGH
        access(0, 1'b0, 1'b1, 32'd1036, 32'h77775555, dc, res);
        check("pre1036_hi", {16'h0, mem_a[7]}, 32'h00007777);

        drive(0, 1'b0, 1'b1, 32'd1036, 32'h11112222);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort_we_n_held", {31'h0, we_a_n}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("abort_ready",  {31'h0, bus_a.ready}, 32'h1);
        check("abort_we_n",   {31'h0, we_a_n}, 32'h1);
        check("abort_addr",   {14'h0, addr_a}, 32'h0);
        check("abort_result", bus_a.MEM_result, 32'h0);
        check("abort_bus",    {16'h0, dq_a}, 32'h0000BEEF);
        check("abort_lo",     {16'h0, mem_a[6]}, 32'h00002222);
        check("abort_hi",     {16'h0, mem_a[7]}, 32'h00007777);
        @(posedge clk); #1;

        // N=1: load two words, then back-to-back reads
        access(1, 1'b0, 1'b1, 32'd1024, 32'h87654321, dc, res);
        check("b_wr_lat", dc, 32'd3);
        access(1, 1'b0, 1'b1, 32'd1028, 32'h0BA9CDEF, dc, res);
        check("b_wr_hi", {16'h0, mem_b[3]}, 32'h00000BA9);

        drive(1, 1'b1, 1'b0, 32'd1024, 32'h0);
        first_c  = -1;
        second_c = -1;
        r1 = 32'h0;
        r2 = 32'h0;
        for (int c = 0; c < 20 && second_c < 0; c++) begin
            if (c > 0) begin
                @(posedge clk); #2;
            end else begin
                #1;
            end
            if (bus_b.ready) begin
                if (first_c < 0) begin
                    first_c = c;
                    r1 = bus_b.MEM_result;
                    drive(1, 1'b1, 1'b0, 32'd1028, 32'h0);
                end else begin
                    second_c = c;
                    r2 = bus_b.MEM_result;
                    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
                end
            end
        end
        check("b2b_done1", first_c, 32'd3);
        check("b2b_data1", r1, 32'h87654321);
        check("b2b_done2", second_c, 32'd7);
        check("b2b_data2", r2, 32'h0BA9CDEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
